// File: rtl/freqdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package freqdiv_pkg;

  localparam logic [1:0] MODE_HALF  = 2'd0;
  localparam logic [1:0] MODE_PULSE = 2'd1;
  localparam int         MIN_DIV    = 2;

  // ceil(v/2) computed with one extra bit so the +1 cannot overflow
  function automatic logic [31:0] half_up(input logic [31:0] v);
    logic [32:0] s;
    s = {1'b0, v} + 33'd1;
    return s[32:1];
  endfunction

endpackage

// File: rtl/freqdiv_halfcyc.sv
// Half-cycle retime flop: captures d on the falling edge, cleared while rst is high.
module freqdiv_halfcyc (
  input  logic clkin,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(negedge clkin) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/freqdiv_prog.sv
// Programmable divider: 50% duty (even/odd) or pulse output, shadowed divisor
// adopted at period boundaries, and a stop that completes the running period.
module freqdiv_prog
  import freqdiv_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] n,
  input  logic         load,
  input  logic [1:0]   mode,
  output logic         clkout,
  output logic         tick,
  output logic         active,
  output logic         n_err
);

  logic [W-1:0] pc_reg, pc_next;
  logic [W-1:0] n_act_reg, n_act_next;
  logic [W-1:0] n_pend_reg, n_pend_next;
  logic [1:0]   mode_act_reg, mode_act_next;
  logic         active_reg, active_next;
  logic         pos_hi_reg, pos_hi_next;
  logic         tick_reg, tick_next;
  logic         load_pend_reg, load_pend_next;
  logic         n_err_reg, n_err_next;
  logic         neg_hi;
  logic         load_ok, load_bad, wrap;
  logic [W:0]   pc_inc, half_n;

  assign load_ok  = load && (n >= W'(MIN_DIV));
  assign load_bad = load && !load_ok;
  // n_act is never below 2, so n_act-1 cannot underflow
  assign wrap     = active_reg && (pc_reg == n_act_reg - W'(1));
  assign pc_inc   = {1'b0, pc_reg} + (W+1)'(1);
  assign half_n   = (W+1)'(half_up(32'(n_act_reg)));

  always_comb begin
    pc_next        = pc_reg;
    n_act_next     = n_act_reg;
    n_pend_next    = n_pend_reg;
    mode_act_next  = mode_act_reg;
    active_next    = active_reg;
    pos_hi_next    = pos_hi_reg;
    tick_next      = 1'b0;
    load_pend_next = load_pend_reg;
    n_err_next     = n_err_reg;

    if (load_ok) begin
      n_pend_next    = n;
      load_pend_next = 1'b1;
      n_err_next     = 1'b0;
    end else if (load_bad) begin
      n_err_next = 1'b1;
    end

    if (!active_reg || wrap) begin
      // Boundary (or idle): adopt a divisor latched in an earlier cycle only
      if (load_pend_reg) begin
        n_act_next = n_pend_reg;
        if (!load_ok) load_pend_next = 1'b0;
      end
      pc_next = '0;
      if (en) begin
        active_next   = 1'b1;
        pos_hi_next   = 1'b1;
        tick_next     = 1'b1;
        mode_act_next = mode;
      end else begin
        active_next = 1'b0;
        pos_hi_next = 1'b0;
      end
    end else begin
      pc_next     = pc_inc[W-1:0];
      pos_hi_next = (mode_act_reg == MODE_PULSE) ? 1'b0 : (pc_inc < half_n);
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      pc_reg        <= '0;
      n_act_reg     <= W'(DEF_DIV);
      n_pend_reg    <= W'(DEF_DIV);
      mode_act_reg  <= MODE_HALF;
      active_reg    <= 1'b0;
      pos_hi_reg    <= 1'b0;
      tick_reg      <= 1'b0;
      load_pend_reg <= 1'b0;
      n_err_reg     <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      n_act_reg     <= n_act_next;
      n_pend_reg    <= n_pend_next;
      mode_act_reg  <= mode_act_next;
      active_reg    <= active_next;
      pos_hi_reg    <= pos_hi_next;
      tick_reg      <= tick_next;
      load_pend_reg <= load_pend_next;
      n_err_reg     <= n_err_next;
    end
  end

  freqdiv_halfcyc u_halfcyc (
    .clkin (clkin),
    .rst   (rst),
    .d     (pos_hi_reg),
    .q     (neg_hi)
  );

  // Odd divisors stretch the low phase by half a cycle via the negedge copy
  always_comb begin
    if (mode_act_reg == MODE_PULSE) clkout = pos_hi_reg;
    else if (n_act_reg[0])          clkout = pos_hi_reg & neg_hi;
    else                            clkout = pos_hi_reg;
  end

  assign tick   = tick_reg;
  assign active = active_reg;
  assign n_err  = n_err_reg;

endmodule
